// File: rtl/video_timing_meter.sv
// video_timing_meter: measures the raster produced by the pattern generator from its
// DE/HS/VS strobes and reports per-frame totals, consistency and frame-to-frame stability.
module video_timing_meter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vid_de,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic        hs_polarity,
    input  logic        vs_polarity,
    output logic [11:0] meas_h_total,
    output logic [11:0] meas_h_active,
    output logic [11:0] meas_v_total,
    output logic [11:0] meas_v_active,
    output logic        meas_valid,
    output logic        meas_stable,
    output logic        meas_err,
    output logic        frame_done
);
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    state_t state, state_nxt;

    logic        de_p0, hs_a_p0, vs_a_p0;
    logic        de_p1, hs_a_p1, vs_a_p1, hs_edge_p1, vs_edge_p1;
    logic [11:0] pix_cnt, de_cnt, line_cnt, act_lines;
    logic [11:0] frame_h_total, frame_h_active;
    logic        h_seen, frame_err;
    logic        sync_lost, line_bad, cnt_ovf, frame_latch, same_vals;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == CNT_MAX) ? v : v + 12'd1;
    endfunction

    // Stage p0: input register, sync folded to active-high.
    // History resets to "active" so a sync already asserted at release is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de_p0   <= 1'b0;
            hs_a_p0 <= 1'b1;
            vs_a_p0 <= 1'b1;
        end else begin
            de_p0   <= vid_de;
            hs_a_p0 <= vid_hs ~^ hs_polarity;
            vs_a_p0 <= vid_vs ~^ vs_polarity;
        end
    end

    // Stage p1: registered line/frame start strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de_p1      <= 1'b0;
            hs_a_p1    <= 1'b1;
            vs_a_p1    <= 1'b1;
            hs_edge_p1 <= 1'b0;
            vs_edge_p1 <= 1'b0;
        end else begin
            de_p1      <= de_p0;
            hs_a_p1    <= hs_a_p0;
            vs_a_p1    <= vs_a_p0;
            hs_edge_p1 <= hs_a_p0 & ~hs_a_p1;
            vs_edge_p1 <= vs_a_p0 & ~vs_a_p1;
        end
    end

    // Stage p2: counters, frame accumulators and result latch.
    // The line closed by an HS edge coincident with VS is not part of the outgoing frame.
    assign sync_lost = (pix_cnt == CNT_MAX) && !hs_edge_p1;
    assign line_bad  = hs_edge_p1 && !vs_edge_p1 && h_seen && (pix_cnt != frame_h_total);
    assign cnt_ovf   = (pix_cnt == CNT_MAX) || (de_cnt == CNT_MAX) ||
                       (line_cnt == CNT_MAX) || (act_lines == CNT_MAX);
    assign same_vals = (frame_h_total == meas_h_total) && (frame_h_active == meas_h_active) &&
                       (line_cnt == meas_v_total) && (act_lines == meas_v_active);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt <= '0;
            de_cnt  <= '0;
        end else if (hs_edge_p1) begin
            pix_cnt <= 12'd1;
            de_cnt  <= {11'd0, de_p1};
        end else begin
            pix_cnt <= sat_inc(pix_cnt);
            if (de_p1) de_cnt <= sat_inc(de_cnt);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_cnt       <= '0;
            act_lines      <= '0;
            frame_h_total  <= '0;
            frame_h_active <= '0;
            h_seen         <= 1'b0;
            frame_err      <= 1'b0;
        end else if (vs_edge_p1) begin
            line_cnt       <= hs_edge_p1 ? 12'd1 : 12'd0;
            act_lines      <= '0;
            frame_h_total  <= '0;
            frame_h_active <= '0;
            h_seen         <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            if (hs_edge_p1) begin
                line_cnt <= sat_inc(line_cnt);
                if (!h_seen) begin
                    frame_h_total <= pix_cnt;
                    h_seen        <= 1'b1;
                end
                if (de_cnt != 12'd0) begin
                    frame_h_active <= de_cnt;
                    act_lines      <= sat_inc(act_lines);
                end
            end
            if (line_bad || cnt_ovf) frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SEARCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_latch = 1'b0;
        case (state)
            SEARCH:  if (vs_edge_p1) state_nxt = MEASURE;
            MEASURE: if (vs_edge_p1) begin
                         state_nxt   = LOCKED;
                         frame_latch = 1'b1;
                     end
            LOCKED:  if (vs_edge_p1) frame_latch = 1'b1;
            default: state_nxt = SEARCH;
        endcase
        if (sync_lost) begin
            state_nxt   = SEARCH;
            frame_latch = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meas_h_total  <= '0;
            meas_h_active <= '0;
            meas_v_total  <= '0;
            meas_v_active <= '0;
            meas_valid    <= 1'b0;
            meas_stable   <= 1'b0;
            meas_err      <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= frame_latch;
            if (frame_latch) begin
                meas_h_total  <= frame_h_total;
                meas_h_active <= frame_h_active;
                meas_v_total  <= line_cnt;
                meas_v_active <= act_lines;
                meas_err      <= frame_err | cnt_ovf;
                meas_valid    <= 1'b1;
                meas_stable   <= (state == LOCKED) && same_vals &&
                                 !frame_err && !cnt_ovf && !meas_err;
            end else if (sync_lost) begin
                meas_valid  <= 1'b0;
                meas_stable <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_video_timing_meter.sv
// Bench for video_timing_meter: drives synthetic rasters and compares every reported
// frame with results derived from the raster geometry by a frame-level model.
module tb_video_timing_meter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vid_de = 1'b0, vid_hs = 1'b1, vid_vs = 1'b1;
    logic        hs_polarity = 1'b0, vs_polarity = 1'b0;
    logic [11:0] meas_h_total, meas_h_active, meas_v_total, meas_v_active;
    logic        meas_valid, meas_stable, meas_err, frame_done;

    always #5 clk = ~clk;

    video_timing_meter dut (
        .clk(clk), .reset_n(reset_n), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
        .hs_polarity(hs_polarity), .vs_polarity(vs_polarity),
        .meas_h_total(meas_h_total), .meas_h_active(meas_h_active),
        .meas_v_total(meas_v_total), .meas_v_active(meas_v_active),
        .meas_valid(meas_valid), .meas_stable(meas_stable), .meas_err(meas_err),
        .frame_done(frame_done)
    );

    typedef struct {
        int ht; int ha; int vt; int va; bit err; bit stable;
    } res_t;

    res_t exp_q[$];
    res_t pending, prev;
    bit   m_search = 1'b1, m_locked = 1'b0;
    int   checks = 0, errors = 0;
    int   cyc = 0, vs_cyc = -100;
    logic vs_prev = 1'b0;
    logic hs_lvl = 1'b0, vs_lvl = 1'b0;
    int   hsw, hbp, ha, hfp, vsw, vbp, va, vfp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic see_done();
        res_t e;
        check("done_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("latency", cyc - vs_cyc, 3);
            check("h_total", meas_h_total, e.ht);
            check("h_active", meas_h_active, e.ha);
            check("v_total", meas_v_total, e.vt);
            check("v_active", meas_v_active, e.va);
            check("valid", meas_valid, 1);
            check("stable", meas_stable, e.stable);
            check("err", meas_err, e.err);
        end
    endtask

    // One pixel clock: drive after the edge, observe at the falling edge.
    task automatic pix(input logic de, input logic hs, input logic vs);
        @(posedge clk);
        #1;
        vid_de = de; vid_hs = hs; vid_vs = vs;
        cyc++;
        if ((vs ~^ vs_polarity) && !vs_prev) vs_cyc = cyc;
        vs_prev = vs ~^ vs_polarity;
        @(negedge clk);
        if (frame_done === 1'b1) see_done();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(1'b0, ~hs_lvl, ~vs_lvl);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_h_total"}, meas_h_total, 0);
        check({tag, "_h_active"}, meas_h_active, 0);
        check({tag, "_v_total"}, meas_v_total, 0);
        check({tag, "_v_active"}, meas_v_active, 0);
        check({tag, "_valid"}, meas_valid, 0);
        check({tag, "_stable"}, meas_stable, 0);
        check({tag, "_err"}, meas_err, 0);
        check({tag, "_done"}, frame_done, 0);
    endtask

    // A frame boundary as the meter should see it.
    task automatic model_edge();
        res_t e;
        if (m_search) begin
            m_search = 1'b0;
            m_locked = 1'b0;
        end else begin
            e = pending;
            e.stable = m_locked && !pending.err && !prev.err &&
                       pending.ht == prev.ht && pending.ha == prev.ha &&
                       pending.vt == prev.vt && pending.va == prev.va;
            exp_q.push_back(e);
            prev = pending;
            m_locked = 1'b1;
        end
    endtask

    task automatic frame(input int stretch, input int rst_line);
        int ht, vt, len;
        logic de;
        ht = hsw + hbp + ha + hfp;
        vt = vsw + vbp + va + vfp;
        model_edge();
        pending.ht = ht; pending.ha = ha; pending.vt = vt; pending.va = va;
        pending.err = (stretch >= 0); pending.stable = 1'b0;
        for (int y = 0; y < vt; y++) begin
            len = (y == stretch) ? ht + 1 : ht;
            for (int x = 0; x < len; x++) begin
                de = (y >= vsw + vbp) && (y < vsw + vbp + va) &&
                     (x >= hsw + hbp) && (x < hsw + hbp + ha);
                pix(de, (x < hsw) ? hs_lvl : ~hs_lvl, (y < vsw) ? vs_lvl : ~vs_lvl);
                if (y == rst_line && x == 2) begin
                    #1 reset_n = 1'b0;
                    #1 check_zero("async_reset");
                    m_search = 1'b1;
                end
                if (y == rst_line && x == 6) #1 reset_n = 1'b1;
            end
        end
    endtask

    task automatic stall();
        int ht;
        ht = hsw + hbp + ha + hfp;
        for (int s = 0; s < 5000; s++) begin
            pix(1'b0, ~hs_lvl, ~vs_lvl);
            if (s == 4097 - ht) begin
                check("valid_before_loss", meas_valid, 1);
                check("stable_before_loss", meas_stable, 1);
            end
            if (s == 4098 - ht) begin
                check("valid_after_loss", meas_valid, 0);
                check("stable_after_loss", meas_stable, 0);
                check("held_h_total", meas_h_total, ht);
                check("held_v_total", meas_v_total, vsw + vbp + va + vfp);
            end
        end
        m_search = 1'b1;
    endtask

    task automatic switch_pol(input logic hp, input logic vp, input logic hl, input logic vl);
        #1 reset_n = 1'b0;
        #1 check_zero("pol_reset");
        m_search = 1'b1;
        hs_polarity = hp; vs_polarity = vp; hs_lvl = hl; vs_lvl = vl;
        idle(2);
        #1 reset_n = 1'b1;
        idle(4);
    endtask

    task automatic set_raster(input int a, input int b, input int c, input int d,
                              input int e, input int f, input int g, input int h);
        hsw = a; hbp = b; ha = c; hfp = d; vsw = e; vbp = f; va = g; vfp = h;
    endtask

    initial begin
        set_raster(4, 5, 24, 3, 2, 2, 6, 1);
        repeat (3) @(negedge clk);
        check_zero("reset");
        #1 reset_n = 1'b1;
        idle(4);

        // steady raster, then one stretched line, then clean frames
        repeat (4) frame(-1, -1);
        frame(-1, -1);
        frame(5, -1);
        repeat (3) frame(-1, -1);

        // loss of HS while locked, then recovery
        stall();
        repeat (3) frame(-1, -1);

        // asynchronous reset in the middle of a frame
        frame(-1, 6);
        repeat (3) frame(-1, -1);

        // inverted sync with matching polarity, then mismatched polarity
        switch_pol(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) frame(-1, -1);
        switch_pol(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) frame(-1, -1);

        // wide lines, then a mode change without reset
        switch_pol(1'b0, 1'b0, 1'b0, 1'b0);
        set_raster(96, 48, 640, 16, 1, 1, 4, 1);
        repeat (3) frame(-1, -1);
        set_raster(136, 160, 1024, 24, 1, 1, 3, 1);
        repeat (3) frame(-1, -1);

        // random small rasters
        for (int r = 0; r < 3; r++) begin
            set_raster($urandom_range(6, 1), $urandom_range(6, 1), $urandom_range(40, 8),
                       $urandom_range(4, 1), $urandom_range(3, 1), $urandom_range(3, 1),
                       $urandom_range(8, 2), $urandom_range(3, 1));
            repeat (3) frame(-1, -1);
        end

        // close the last frame with one more VS edge
        model_edge();
        for (int x = 0; x < hsw + hbp + ha + hfp; x++)
            pix(1'b0, (x < hsw) ? hs_lvl : ~hs_lvl, vs_lvl);
        idle(8);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
